// File: rtl/addsub_serial_ctrl_if.sv
// Handshake/bus bundle for addsub_serial_ctrl.
// Valid/ready semantics for both channels: a transfer happens on a rising
// edge where valid and ready are both high. The sender holds its payload
// stable while valid is high; ready may be raised or lowered at any time.
interface addsub_serial_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] S;
    logic             C;
    logic             V;
    logic             Z;
    logic             busy;

    // Operand source / result consumer side
    modport master (
        output start_valid, A, B, sub, res_ready,
        input  start_ready, res_valid, S, C, V, Z, busy
    );

    // Controller side
    modport slave (
        input  start_valid, A, B, sub, res_ready,
        output start_ready, res_valid, S, C, V, Z, busy
    );
endinterface

// File: rtl/addsub_serial_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice stepped LSB-first
// over WIDTH clocks, with operand and result valid/ready channels.
// Optional macro ADDSUB_SERIAL_FLAGS_EN enables the V (signed overflow) and
// Z (zero) flags; without it both are tied to 0 and their logic is absent.
// dbg_state_o exposes the FSM state for checkers.
module addsub_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_serial_ctrl_if.slave  bus,
    output logic [1:0]           dbg_state_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;

    // Full-adder slice on the current LSBs
    logic             sum_bit;
    logic             carry_nx;
    logic [WIDTH-1:0] s_shift;
    logic             last_step;

    assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_nx  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign s_shift   = {sum_bit, s_q[WIDTH-1:1]};
    assign last_step = (cnt_q == CW'(WIDTH - 1));

`ifdef ADDSUB_SERIAL_FLAGS_EN
    logic v_q, v_d;
    logic z_q, z_d;
    logic c_msb;
    // During the last step carry_q is the carry into the MSB position.
    assign c_msb = carry_q;
`endif

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_d     = c_q;
`ifdef ADDSUB_SERIAL_FLAGS_EN
        v_d     = v_q;
        z_d     = z_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    // Subtract is A + ~B + 1: invert B and seed the carry with 1.
                    a_sh_d  = bus.A;
                    b_sh_d  = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_d     = s_shift;
                carry_d = carry_nx;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (last_step) begin
                    c_d     = carry_nx;
`ifdef ADDSUB_SERIAL_FLAGS_EN
                    v_d     = c_msb ^ carry_nx;
                    z_d     = (s_shift == '0);
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_q     <= c_d;
        end
    end

`ifdef ADDSUB_SERIAL_FLAGS_EN
    // Overflow and zero flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            v_q <= v_d;
            z_q <= z_d;
        end
    end

    assign bus.V = v_q;
    assign bus.Z = z_q;
`else
    assign bus.V = 1'b0;
    assign bus.Z = 1'b0;
`endif

    // Outputs are decoded from registers only
    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.res_valid   = (state_q == ST_DONE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.S           = s_q;
    assign bus.C           = c_q;
    assign dbg_state_o     = state_q;
endmodule
